// File: rtl/radix4_mult_pkg.sv
// Shared state encoding, Booth digit codes and iteration count for radix4_mult_seq.
// ST_ACC exists only when RADIX4_MAC_EN is defined.
package radix4_mult_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD_A = 3'd1,
        ST_LOAD_B = 3'd2,
        ST_CALC   = 3'd3,
        ST_OUT    = 3'd4
`ifdef RADIX4_MAC_EN
        , ST_ACC  = 3'd5
`endif
    } state_e;

    typedef enum logic [2:0] {
        DIG_ZERO = 3'd0,
        DIG_P1   = 3'd1,
        DIG_P2   = 3'd2,
        DIG_M2   = 3'd3,
        DIG_M1   = 3'd4
    } booth_digit_e;

    // One iteration per bit pair of the WIDTH+2 extended operand.
    function automatic int unsigned iter_f(input int unsigned width);
        return width / 2 + 1;
    endfunction

endpackage

// File: rtl/booth4_enc.sv
// Radix-4 Booth encoder: maps {a[1:0], a_prev} and the extended B to the
// signed multiple (0, +-B, +-2B) sign-extended to WIDTH+4 bits.
module booth4_enc
    import radix4_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8
)
(
    input  logic [2:0]       sel_i,
    input  logic [WIDTH+1:0] b_ext_i,
    output logic [WIDTH+3:0] mult_o_c
);

    localparam int unsigned MW = WIDTH + 4;

    booth_digit_e  digit;
    logic [MW-1:0] b1;
    logic [MW-1:0] b2;

    assign b1 = {{2{b_ext_i[WIDTH+1]}}, b_ext_i};
    assign b2 = {b1[MW-2:0], 1'b0};

    always_comb begin
        digit = DIG_ZERO;
        case (sel_i)
            3'b001, 3'b010: digit = DIG_P1;
            3'b011:         digit = DIG_P2;
            3'b100:         digit = DIG_M2;
            3'b101, 3'b110: digit = DIG_M1;
            default:        digit = DIG_ZERO;
        endcase
    end

    always_comb begin
        mult_o_c = '0;
        case (digit)
            DIG_P1:  mult_o_c = b1;
            DIG_P2:  mult_o_c = b2;
            DIG_M2:  mult_o_c = -b2;
            DIG_M1:  mult_o_c = -b1;
            default: mult_o_c = '0;
        endcase
    end

endmodule

// File: rtl/radix4_mult_seq.sv
// Sequential radix-4 Booth multiplier: chunked operand load, WIDTH/2+1 cycle
// multiply, chunked product readout. Define RADIX4_MAC_EN for multiply-accumulate.
module radix4_mult_seq
    import radix4_mult_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IN_W  = 4
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic                 ld_a,
    input  logic                 ld_b,
    input  logic [IN_W-1:0]      data_in,
    input  logic                 put_out,
`ifdef RADIX4_MAC_EN
    input  logic                 accumulate,
`endif
    output logic [IN_W-1:0]      data_out,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy,
    output logic                 done
);

    localparam int unsigned NCHUNK = WIDTH / IN_W;
    localparam int unsigned ITER   = iter_f(WIDTH);
    localparam int unsigned PW     = 2 * WIDTH;
    localparam int unsigned XW     = WIDTH + 2;
    localparam int unsigned HW     = WIDTH + 4;
    localparam int unsigned CNT_W  = $clog2(2 * NCHUNK);
    localparam int unsigned IT_W   = $clog2(ITER);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  chunk_q, chunk_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [IT_W-1:0]   iter_q, iter_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic              sgn_q, sgn_d;
    logic [XW-1:0]     a_sh_q, a_sh_d;
    logic              a_prev_q, a_prev_d;
    logic [HW-1:0]     hi_q, hi_d;
    logic [PW-1:0]     product_q, product_d;
    logic [IN_W-1:0]   data_out_q, data_out_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef RADIX4_MAC_EN
    logic              acc_q, acc_d;
    logic [PW-1:0]     acc_res_c;
`endif

    logic              last_chunk_c;
    logic              last_iter_c;
    logic              last_idx_c;
    logic [XW-1:0]     b_ext_c;
    logic [HW-1:0]     mult_c;
    logic [HW-1:0]     sum_c;
    logic [HW-1:0]     hi_nx_c;
    logic [XW-1:0]     a_nx_c;
    logic [PW-1:0]     res_c;

    assign last_chunk_c = (chunk_q == CNT_W'(NCHUNK - 1));
    assign last_iter_c  = (iter_q == IT_W'(ITER - 1));
    assign last_idx_c   = (idx_q == CNT_W'(2 * NCHUNK - 1));

    // One Booth step: add the selected multiple, then shift {hi, a} right by two.
    assign b_ext_c = {{2{sgn_q & b_q[WIDTH-1]}}, b_q};
    assign sum_c   = hi_q + mult_c;
    assign hi_nx_c = {{2{sum_c[HW-1]}}, sum_c[HW-1:2]};
    assign a_nx_c  = {sum_c[1:0], a_sh_q[XW-1:2]};
    assign res_c   = {hi_nx_c[WIDTH-3:0], a_nx_c};
`ifdef RADIX4_MAC_EN
    assign acc_res_c = {hi_q[WIDTH-3:0], a_sh_q};
`endif

    booth4_enc #(.WIDTH(WIDTH)) u_enc (
        .sel_i    ({a_sh_q[1:0], a_prev_q}),
        .b_ext_i  (b_ext_c),
        .mult_o_c (mult_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD_A;
            ST_LOAD_A: if (ld_a && last_chunk_c) state_d = ST_LOAD_B;
            ST_LOAD_B: if (ld_b && last_chunk_c) state_d = ST_CALC;
`ifdef RADIX4_MAC_EN
            ST_CALC:   if (last_iter_c) state_d = acc_q ? ST_ACC : ST_OUT;
            ST_ACC:    state_d = ST_OUT;
`else
            ST_CALC:   if (last_iter_c) state_d = ST_OUT;
`endif
            ST_OUT:    if (put_out && last_idx_c) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        chunk_d   = chunk_q;
        idx_d     = idx_q;
        iter_d    = iter_q;
        a_d       = a_q;
        b_d       = b_q;
        sgn_d     = sgn_q;
        a_sh_d    = a_sh_q;
        a_prev_d  = a_prev_q;
        hi_d      = hi_q;
        product_d = product_q;
`ifdef RADIX4_MAC_EN
        acc_d     = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    chunk_d = '0;
                    idx_d   = '0;
                    sgn_d   = signed_mode;
`ifdef RADIX4_MAC_EN
                    acc_d   = accumulate;
`endif
                end
            end
            ST_LOAD_A: begin
                if (ld_a) begin
                    for (int unsigned k = 0; k < NCHUNK; k++) begin
                        if (CNT_W'(k) == chunk_q) a_d[k*IN_W +: IN_W] = data_in;
                    end
                    chunk_d = last_chunk_c ? '0 : chunk_q + CNT_W'(1);
                end
            end
            ST_LOAD_B: begin
                if (ld_b) begin
                    for (int unsigned k = 0; k < NCHUNK; k++) begin
                        if (CNT_W'(k) == chunk_q) b_d[k*IN_W +: IN_W] = data_in;
                    end
                    chunk_d = last_chunk_c ? '0 : chunk_q + CNT_W'(1);
                    // Seed the shift register so CALC starts iterating on its first cycle.
                    if (last_chunk_c) begin
                        a_sh_d   = {{2{sgn_q & a_q[WIDTH-1]}}, a_q};
                        a_prev_d = 1'b0;
                        hi_d     = '0;
                        iter_d   = '0;
                    end
                end
            end
            ST_CALC: begin
                hi_d     = hi_nx_c;
                a_sh_d   = a_nx_c;
                a_prev_d = a_sh_q[1];
                iter_d   = iter_q + IT_W'(1);
                if (last_iter_c) begin
                    iter_d = '0;
                    idx_d  = '0;
`ifdef RADIX4_MAC_EN
                    // With accumulate the old product is kept for the ACC add.
                    if (!acc_q) product_d = res_c;
`else
                    product_d = res_c;
`endif
                end
            end
`ifdef RADIX4_MAC_EN
            ST_ACC: begin
                product_d = product_q + acc_res_c;
            end
`endif
            ST_OUT: begin
                if (put_out) idx_d = last_idx_c ? '0 : idx_q + CNT_W'(1);
            end
            default: begin
                chunk_d = '0;
            end
        endcase

        data_out_d = '0;
        for (int unsigned k = 0; k < 2 * NCHUNK; k++) begin
            if (CNT_W'(k) == idx_d) data_out_d = product_d[k*IN_W +: IN_W];
        end
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_OUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            chunk_q    <= '0;
            idx_q      <= '0;
            iter_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            sgn_q      <= 1'b0;
            a_sh_q     <= '0;
            a_prev_q   <= 1'b0;
            hi_q       <= '0;
            product_q  <= '0;
            data_out_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef RADIX4_MAC_EN
            acc_q      <= 1'b0;
`endif
        end else begin
            chunk_q    <= chunk_d;
            idx_q      <= idx_d;
            iter_q     <= iter_d;
            a_q        <= a_d;
            b_q        <= b_d;
            sgn_q      <= sgn_d;
            a_sh_q     <= a_sh_d;
            a_prev_q   <= a_prev_d;
            hi_q       <= hi_d;
            product_q  <= product_d;
            data_out_q <= data_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef RADIX4_MAC_EN
            acc_q      <= acc_d;
`endif
        end
    end

    assign data_out = data_out_q;
    assign product  = product_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_radix4_mult_seq.sv
// Scoreboard bench for radix4_mult_seq (WIDTH=8, IN_W=4): directed operations push
// expected products; a monitor checks product and every readout chunk while done.
module tb_radix4_mult_seq;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned IN_W  = 4;
    localparam int unsigned ITER  = WIDTH / 2 + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        signed_mode;
    logic        ld_a;
    logic        ld_b;
    logic [3:0]  data_in;
    logic        put_out;
`ifdef RADIX4_MAC_EN
    logic        accumulate;
`endif
    logic [3:0]  data_out;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] exp_q[$];
    logic        acc_req;

    radix4_mult_seq #(.WIDTH(WIDTH), .IN_W(IN_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .ld_a        (ld_a),
        .ld_b        (ld_b),
        .data_in     (data_in),
        .put_out     (put_out),
`ifdef RADIX4_MAC_EN
        .accumulate  (accumulate),
`endif
        .data_out    (data_out),
        .product     (product),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pop on the rising edge of done, then check each presented chunk.
    initial begin : monitor
        logic        dprev;
        int          idx;
        logic [15:0] cur;
        dprev = 1'b0;
        idx   = 0;
        cur   = '0;
        forever begin
            @(negedge clk);
            if (done && !dprev) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: product 0x%04h with nothing expected", product);
                    cur = '0;
                end else begin
                    cur = exp_q.pop_front();
                    check("product", 32'(product), 32'(cur));
                end
                idx = 0;
            end
            if (done) begin
                if (idx < 4) check($sformatf("data_out[%0d]", idx), 32'(data_out), 32'(cur[idx*4 +: 4]));
                if (put_out) idx++;
            end
            dprev = done;
        end
    end

    // Start and load both operands; returns in the first CALC cycle.
    task automatic load_op(input logic [7:0] a, input logic [7:0] b, input logic sm, input bit noise);
        start       = 1'b1;
        signed_mode = sm;
`ifdef RADIX4_MAC_EN
        accumulate  = acc_req;
`endif
        tick();
        start       = 1'b0;
        signed_mode = ~sm;
`ifdef RADIX4_MAC_EN
        accumulate  = ~acc_req;
`endif
        if (noise) begin
            ld_b = 1'b1; data_in = 4'hF; tick(); ld_b = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            ld_a = 1'b1; ld_b = noise; data_in = a[k*4 +: 4]; tick();
        end
        ld_a = 1'b0; ld_b = 1'b0;
        if (noise) begin
            ld_a = 1'b1; data_in = 4'hF; tick(); ld_a = 1'b0;
        end
        for (int k = 0; k < 2; k++) begin
            ld_b = 1'b1; data_in = b[k*4 +: 4]; tick();
        end
        ld_b = 1'b0;
        data_in = 4'h0;
    endtask

    // Expect a result, measure latency from the last ld_b, then read it out.
    task automatic finish_op(input logic [15:0] exp, input bit noise);
        int n;
        exp_q.push_back(exp);
        n = 1;
        if (noise) start = 1'b1;
        while (!done && n < 40) begin
            tick();
            start = 1'b0;
            n++;
        end
        start = 1'b0;
        check("calc_latency", 32'(n), 32'(ITER + 1 + (acc_req ? 1 : 0)));
        for (int k = 0; k < 4; k++) begin
            put_out = 1'b1;
            tick();
            put_out = 1'b0;
            if (noise && k == 1) tick();
        end
        check("busy_after_readout", 32'(busy), 32'(0));
        check("done_after_readout", 32'(done), 32'(0));
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        rst = 1'b1; start = 1'b0; signed_mode = 1'b0; ld_a = 1'b0; ld_b = 1'b0;
        data_in = 4'h0; put_out = 1'b0; acc_req = 1'b0;
`ifdef RADIX4_MAC_EN
        accumulate = 1'b0;
`endif
        tick(); tick();
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'(0));
        check("reset_done", 32'(done), 32'(0));
        check("reset_product", 32'(product), 32'(0));
        check("reset_data_out", 32'(data_out), 32'(0));

        // put_out in IDLE must not move the readout index
        put_out = 1'b1; tick(); tick(); put_out = 1'b0;
        check("idle_put_out_busy", 32'(busy), 32'(0));

        load_op(8'h07, 8'h06, 1'b0, 1'b0); finish_op(16'h002A, 1'b0);
        load_op(8'hFF, 8'h80, 1'b1, 1'b1); finish_op(16'h0080, 1'b1);
        load_op(8'hFF, 8'h80, 1'b0, 1'b0); finish_op(16'h7F80, 1'b0);
        load_op(8'hFF, 8'hFF, 1'b0, 1'b1); finish_op(16'hFE01, 1'b1);
        load_op(8'h80, 8'h80, 1'b1, 1'b0); finish_op(16'h4000, 1'b0);
        load_op(8'hFD, 8'h05, 1'b1, 1'b0); finish_op(16'hFFF1, 1'b0);

        // Reset on the third CALC cycle
        load_op(8'h12, 8'h34, 1'b0, 1'b0);
        tick(); tick();
        check("mid_calc_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("post_reset_busy", 32'(busy), 32'(0));
        check("post_reset_done", 32'(done), 32'(0));
        check("post_reset_product", 32'(product), 32'(0));
        check("post_reset_data_out", 32'(data_out), 32'(0));
        load_op(8'h03, 8'h05, 1'b0, 1'b0); finish_op(16'h000F, 1'b0);

`ifdef RADIX4_MAC_EN
        load_op(8'hFF, 8'hFF, 1'b0, 1'b0); finish_op(16'hFE01, 1'b0);
        acc_req = 1'b1;
        load_op(8'h02, 8'h03, 1'b0, 1'b0); finish_op(16'hFE07, 1'b0);
        acc_req = 1'b0;
`endif

        tick(); tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/radix4_mult_seq.md
# radix4_mult_seq

Parametrised sequential radix-4 Booth multiplier with its controller and datapath in one block. Operands arrive over a narrow chunk bus and are loaded one chunk per strobe. Signed or unsigned multiply is selected per operation, and the 2·WIDTH product is read back chunk by chunk. It is the next generation of the lab multiplier: any even width, any chunk width, a mode input, busy/done status, and an optional multiply-accumulate.

## Interface
Parameters:
- WIDTH, 8: operand width. Must be even and ≥ 4.
- IN_W, 4: chunk width. Must divide WIDTH. NCHUNK = WIDTH/IN_W.

Ports (reset is synchronous and active-high; single clock `clk`, reset `rst`):
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  begin an operation; honoured in IDLE only
- signed_mode  in  1  1 = two's-complement operands; sampled on the accepted start
- ld_a  in  1  capture data_in as the next A chunk
- ld_b  in  1  capture data_in as the next B chunk
- data_in  in  IN_W  operand chunk
- put_out  in  1  advance the readout chunk index
- data_out  out  IN_W  current product chunk
- product  out  2·WIDTH  full result register
- busy  out  1  high in every state except IDLE
- done  out  1  high in OUT
- accumulate  in  1  present only with RADIX4_MAC_EN; sampled on the accepted start

## Operation
States: IDLE, LOAD_A, LOAD_B, CALC, OUT, plus ACC with the macro.

- **IDLE**
  - start=1 → LOAD_A next cycle.
  - On that start: chunk counter cleared, signed_mode latched, accumulate latched if present.
  - The product register is not cleared.
- **LOAD_A**
  - Each cycle with ld_a=1 writes data_in into A chunk k, LS chunk first, then k++.
  - After the NCHUNK-th capture → LOAD_B, counter cleared.
  - ld_b is ignored in this state.
- **LOAD_B**
  - Same rule using ld_b; ld_a is ignored.
  - After the NCHUNK-th capture → CALC.
- **CALC**
  - Operands are extended to WIDTH+2 bits: sign-extended if the latched mode is signed, zero-extended otherwise.
  - Runs ITER = WIDTH/2+1 iterations, one per cycle.
  - Each iteration, the digit is taken from {a[1], a[0], a_prev}:
    - 000 or 111 → 0
    - 001 or 010 → +B
    - 011 → +2B
    - 100 → −2B
    - 101 or 110 → −B
  - The high accumulator is WIDTH+4 bits, sign-extended. Each iteration adds the digit times B to it, then arithmetic-shifts {hi, a} right by 2; a_prev takes the old a[1].
  - After the last iteration, the low 2·WIDTH bits are written to the product register → OUT (ACC instead if the MAC feature is present and accumulate was latched).
- **OUT**
  - done=1. data_out = product[IN_W·j +: IN_W], with j starting at 0.
  - Each put_out=1 cycle increments j.
  - put_out when j = 2·NCHUNK−1 → IDLE, j cleared.
- **Results**: product is modulo 2^(2·WIDTH) and exact for all operand values in both modes.

## Timing
- **Reset values**: state IDLE; all counters 0; A, B and the accumulator 0; product 0. Outputs are therefore data_out=0, product=0, busy=0, done=0.
- **Reset mid-operation**: rst in any state returns to IDLE on the next edge with every register at its reset value. This takes priority over all other inputs.
- **start**: the cycle with start=1 in IDLE is followed by LOAD_A. start is ignored in all other states.
- **Load strobes**: each strobe is a level sample per cycle. A strobe held for n cycles captures n chunks.
- **CALC latency**: with the last ld_b on cycle t, CALC occupies cycles t+1 to t+ITER. done=1 from t+ITER+1, or t+ITER+2 with ACC.
- **Readout timing**: data_out is registered from product and the index j. It changes the cycle after a put_out.
- **Simultaneous ld_a and ld_b**: only the strobe matching the current state acts.
- **put_out outside OUT**: ignored.

## Configuration
- **RADIX4_MAC_EN defined**
  - Adds the accumulate port and the ACC state.
  - ACC takes one cycle: product ← product_prev + the new product, modulo 2^(2·WIDTH), where product_prev is the value held before this operation.
  - It then goes to OUT, so latency is +1 cycle only when accumulate is latched.
- **RADIX4_MAC_EN undefined**
  - No accumulate port and no ACC state.
  - product is overwritten each operation.

## Structure
- Package `radix4_mult_pkg` holds:
  - the state enum;
  - the 3-bit Booth digit codes (ZERO, P1, P2, M2, M1);
  - the ITER computation as a function of WIDTH.
- Sub-module `booth4_enc`, purely combinational, maps {a[1:0], a_prev} and the extended B to the signed multiple to add.
- The FSM, counters and shift register stay in the top module.

## Test plan
- **Unsigned multiply**: WIDTH=8, IN_W=4, unsigned. Load A chunks 7,0 and B chunks 6,0 → after 5 CALC cycles product=0x002A; readout sequence A,2,0,0; then back in IDLE.
- **Signed corner**: signed, A=0xFF, B=0x80 → product=0x0080. Unsigned, same operands → 0x7F80.
- **Unsigned maximum**: 0xFF × 0xFF → 0xFE01. Signed 0x80 × 0x80 → 0x4000.
- **Ignored strobes**: ld_b pulses during LOAD_A and start pulses during CALC → no capture, no state change, result unaffected.
- **Reset mid-CALC**: rst asserted on the 3rd CALC cycle → next cycle IDLE, product=0, busy=0, done=0. A following operation 3×5 gives 0x000F.
- **MAC** (macro defined): run 0xFF×0xFF unsigned, then 2×3 with accumulate=1 → product=0xFE07, done one cycle later than without accumulate.
